// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state codes and BCD digit geometry.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 7;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned DISP_W     = NUM_DIGITS * DIGIT_W;

  // Largest value held by a units digit (0-9) and a tens-of-sec/min digit (0-5)
  localparam logic [DIGIT_W-1:0] DEC_MAX = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] SEX_MAX = DIGIT_W'(5);

  // 59:59.999 packed as {min_t, min_o, sec_t, sec_o, ms_h, ms_t, ms_o}
  localparam logic [DISP_W-1:0] LIVE_MAX =
    {SEX_MAX, DEC_MAX, SEX_MAX, DEC_MAX, DEC_MAX, DEC_MAX, DEC_MAX};

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_CLEAR  = 4'd1,
    ST_PAUSED = 4'd2,
    ST_RUN    = 4'd3
  } sw_state_e;

endpackage

// File: rtl/stopwatch_control_bcd_digit.sv
// Mod-(MAX+1) BCD digit with increment-in, carry-out and synchronous clear.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = DEC_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [DIGIT_W-1:0] q,
  output logic [DIGIT_W-1:0] nxt_c,
  output logic               carry_c
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  // Next digit value: clear wins, otherwise wrap to zero past MAX
  always_comb begin
    q_d     = q_q;
    carry_c = inc_i && (q_q == MAX);
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i) begin
      q_d = (q_q == MAX) ? '0 : q_q + DIGIT_W'(1);
    end
  end

  // Digit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q     = q_q;
  assign nxt_c = q_d;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control: run/pause/clear FSM, 7-digit BCD counter, lap freeze.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int unsigned ROLLOVER = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        reset_btn,
  input  logic        lap_btn,
  input  logic        oneMilliSecond,
  output logic [3:0]  state,
  output logic [27:0] digits,
  output logic        lap_hold,
  output logic        overflow
);

  sw_state_e             state_q, state_d;
  logic [DISP_W-1:0]     live_q, live_d;
  logic [DISP_W-1:0]     snap_q, snap_d;
  logic [DISP_W-1:0]     digits_q, digits_d;
  logic                  lap_hold_q, lap_hold_d;
  logic                  overflow_q, overflow_d;
  logic [NUM_DIGITS-1:0] carry;
  logic                  reset_req, stop_req, start_req, lap_req;
  logic                  tick_run, at_max, inc_en, clr_live, ovf_evt;

  // Button priority: reset > stop > start > lap
  always_comb begin
    reset_req = reset_btn;
    stop_req  = !reset_btn && stop_btn;
    start_req = !reset_btn && !stop_btn && start_btn;
    lap_req   = !reset_btn && !stop_btn && !start_btn && lap_btn;
  end

  // Next-state logic; reset request overrides every state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_req) state_d = ST_RUN;
      ST_RUN:    if (stop_req)  state_d = ST_PAUSED;
      ST_PAUSED: if (start_req) state_d = ST_RUN;
      ST_CLEAR:  state_d = ST_IDLE;
      default:   state_d = ST_CLEAR;
    endcase
    if (reset_req) state_d = ST_CLEAR;
  end

  // Counter enables; saturate mode blocks the increment at 59:59.999
  always_comb begin
    clr_live = (state_q == ST_CLEAR);
    tick_run = oneMilliSecond && (state_q == ST_RUN);
    at_max   = (live_q == LIVE_MAX);
    inc_en   = tick_run && !(at_max && (ROLLOVER == 0));
    ovf_evt  = (ROLLOVER != 0) ? carry[NUM_DIGITS-1] : (tick_run && at_max);
  end

  // Live counter digits, least significant first, carry rippling upward
  bcd_digit #(.MAX(DEC_MAX)) u_ms_o  (.clk(clk), .rst_n(rst_n), .clr_i(clr_live), .inc_i(inc_en),
    .q(live_q[3:0]),   .nxt_c(live_d[3:0]),   .carry_c(carry[0]));
  bcd_digit #(.MAX(DEC_MAX)) u_ms_t  (.clk(clk), .rst_n(rst_n), .clr_i(clr_live), .inc_i(carry[0]),
    .q(live_q[7:4]),   .nxt_c(live_d[7:4]),   .carry_c(carry[1]));
  bcd_digit #(.MAX(DEC_MAX)) u_ms_h  (.clk(clk), .rst_n(rst_n), .clr_i(clr_live), .inc_i(carry[1]),
    .q(live_q[11:8]),  .nxt_c(live_d[11:8]),  .carry_c(carry[2]));
  bcd_digit #(.MAX(DEC_MAX)) u_sec_o (.clk(clk), .rst_n(rst_n), .clr_i(clr_live), .inc_i(carry[2]),
    .q(live_q[15:12]), .nxt_c(live_d[15:12]), .carry_c(carry[3]));
  bcd_digit #(.MAX(SEX_MAX)) u_sec_t (.clk(clk), .rst_n(rst_n), .clr_i(clr_live), .inc_i(carry[3]),
    .q(live_q[19:16]), .nxt_c(live_d[19:16]), .carry_c(carry[4]));
  bcd_digit #(.MAX(DEC_MAX)) u_min_o (.clk(clk), .rst_n(rst_n), .clr_i(clr_live), .inc_i(carry[4]),
    .q(live_q[23:20]), .nxt_c(live_d[23:20]), .carry_c(carry[5]));
  bcd_digit #(.MAX(SEX_MAX)) u_min_t (.clk(clk), .rst_n(rst_n), .clr_i(clr_live), .inc_i(carry[5]),
    .q(live_q[27:24]), .nxt_c(live_d[27:24]), .carry_c(carry[6]));

  // Lap snapshot, hold flag, sticky overflow and the registered display
  always_comb begin
    snap_d     = snap_q;
    lap_hold_d = lap_hold_q;
    overflow_d = overflow_q || ovf_evt;
    if (clr_live) begin
      snap_d     = '0;
      lap_hold_d = 1'b0;
      overflow_d = 1'b0;
    end else if (lap_req) begin
      if ((state_q == ST_RUN) && !lap_hold_q) begin
        snap_d     = live_q;
        lap_hold_d = 1'b1;
      end else if (((state_q == ST_RUN) || (state_q == ST_PAUSED)) && lap_hold_q) begin
        lap_hold_d = 1'b0;
      end
    end
    digits_d = lap_hold_d ? snap_d : live_d;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      digits_q   <= '0;
      lap_hold_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      digits_q   <= digits_d;
      lap_hold_q <= lap_hold_d;
      overflow_q <= overflow_d;
    end
  end

  assign state    = state_q;
  assign digits   = digits_q;
  assign lap_hold = lap_hold_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Scoreboard bench: one DUT per ROLLOVER setting, driven in lockstep.
module tb_stopwatch_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_btn, stop_btn, reset_btn, lap_btn, tick;
  logic [3:0]  st_r, st_s;
  logic [27:0] dig_r, dig_s;
  logic        lh_r, lh_s, ov_r, ov_s;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [27:0] dr;
    logic [27:0] ds;
    logic        lh;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #10 clk = ~clk;

  stopwatch_control #(.ROLLOVER(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .stop_btn(stop_btn),
    .reset_btn(reset_btn), .lap_btn(lap_btn), .oneMilliSecond(tick),
    .state(st_r), .digits(dig_r), .lap_hold(lh_r), .overflow(ov_r));

  stopwatch_control #(.ROLLOVER(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .stop_btn(stop_btn),
    .reset_btn(reset_btn), .lap_btn(lap_btn), .oneMilliSecond(tick),
    .state(st_s), .digits(dig_s), .lap_hold(lh_s), .overflow(ov_s));

  function automatic logic [27:0] bcd(input int m, input int s, input int ms);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
  endfunction

  task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic expect2(input string nm, input logic [3:0] st, input logic [27:0] dr,
                         input logic [27:0] ds, input logic lh, input logic ov);
    exp_t x;
    x.name = nm; x.st = st; x.dr = dr; x.ds = ds; x.lh = lh; x.ov = ov;
    sb.push_back(x);
  endtask

  task automatic expect1(input string nm, input logic [3:0] st, input logic [27:0] d,
                         input logic lh, input logic ov);
    expect2(nm, st, d, d, lh, ov);
  endtask

  // Apply one cycle of inputs, then return just after the clock edge
  task automatic cyc(input logic st, input logic sp, input logic rs, input logic lp,
                     input logic tk);
    start_btn = st; stop_btn = sp; reset_btn = rs; lap_btn = lp; tick = tk;
    @(posedge clk);
    #1;
    start_btn = 0; stop_btn = 0; reset_btn = 0; lap_btn = 0; tick = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(0, 0, 0, 0, 1);
  endtask

  // Monitor: compare every pending expectation against both DUTs
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, ".state_r"},    28'(st_r), 28'(e.st));
      chk({e.name, ".state_s"},    28'(st_s), 28'(e.st));
      chk({e.name, ".digits_r"},   dig_r,     e.dr);
      chk({e.name, ".digits_s"},   dig_s,     e.ds);
      chk({e.name, ".lap_hold_r"}, 28'(lh_r), 28'(e.lh));
      chk({e.name, ".lap_hold_s"}, 28'(lh_s), 28'(e.lh));
      chk({e.name, ".overflow_r"}, 28'(ov_r), 28'(e.ov));
      chk({e.name, ".overflow_s"}, 28'(ov_s), 28'(e.ov));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] mx;
    mx = bcd(59, 59, 999);
    rst_n = 0;
    start_btn = 0; stop_btn = 0; reset_btn = 0; lap_btn = 0; tick = 0;
    repeat (3) @(posedge clk);
    #1;
    expect1("reset", 4'd0, '0, 0, 0);
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    cyc(0, 0, 0, 0, 1); expect1("idle_tick", 4'd0, '0, 0, 0);
    cyc(1, 0, 0, 0, 0); expect1("start", 4'd3, '0, 0, 0);
    ticks(1500);        expect1("run_1500", 4'd3, bcd(0, 1, 500), 0, 0);

    cyc(0, 0, 1, 0, 0); expect1("rst_btn", 4'd1, bcd(0, 1, 500), 0, 0);
    cyc(0, 0, 0, 0, 0); expect1("clear_done", 4'd0, '0, 0, 0);
    cyc(1, 0, 0, 0, 0); expect1("start2", 4'd3, '0, 0, 0);
    ticks(999);         expect1("at_999", 4'd3, bcd(0, 0, 999), 0, 0);
    cyc(0, 1, 0, 0, 1); expect1("stop_tick", 4'd2, bcd(0, 1, 0), 0, 0);
    ticks(5);           expect1("paused_ticks", 4'd2, bcd(0, 1, 0), 0, 0);

    cyc(1, 0, 1, 0, 0); expect1("start_rst", 4'd1, bcd(0, 1, 0), 0, 0);
    cyc(0, 0, 0, 0, 0); expect1("clr_idle", 4'd0, '0, 0, 0);

    cyc(1, 0, 0, 0, 0); expect1("restart", 4'd3, '0, 0, 0);
    ticks(2345);        expect1("at_2345", 4'd3, bcd(0, 2, 345), 0, 0);
    cyc(0, 0, 0, 1, 0); expect1("lap1", 4'd3, bcd(0, 2, 345), 1, 0);
    ticks(100);         expect1("lap_hold", 4'd3, bcd(0, 2, 345), 1, 0);
    cyc(0, 0, 0, 1, 0); expect1("lap2", 4'd3, bcd(0, 2, 445), 0, 0);
    cyc(0, 0, 0, 1, 1); expect1("lap_tick", 4'd3, bcd(0, 2, 445), 1, 0);
    cyc(0, 0, 0, 0, 1); expect1("hold_tick", 4'd3, bcd(0, 2, 445), 1, 0);
    cyc(0, 1, 0, 0, 0); expect1("stop_hold", 4'd2, bcd(0, 2, 445), 1, 0);
    cyc(0, 0, 0, 1, 0); expect1("paused_unlap", 4'd2, bcd(0, 2, 447), 0, 0);
    cyc(0, 0, 0, 1, 0); expect1("paused_lap_ign", 4'd2, bcd(0, 2, 447), 0, 0);
    cyc(1, 0, 0, 0, 0); expect1("resume", 4'd3, bcd(0, 2, 447), 0, 0);
    cyc(0, 1, 0, 1, 0); expect1("stop_lap", 4'd2, bcd(0, 2, 447), 0, 0);
    cyc(1, 0, 0, 0, 0); expect1("resume2", 4'd3, bcd(0, 2, 447), 0, 0);

    force dut_r.u_ms_o.q_q  = 4'd9; force dut_s.u_ms_o.q_q  = 4'd9;
    force dut_r.u_ms_t.q_q  = 4'd9; force dut_s.u_ms_t.q_q  = 4'd9;
    force dut_r.u_ms_h.q_q  = 4'd9; force dut_s.u_ms_h.q_q  = 4'd9;
    force dut_r.u_sec_o.q_q = 4'd9; force dut_s.u_sec_o.q_q = 4'd9;
    force dut_r.u_sec_t.q_q = 4'd5; force dut_s.u_sec_t.q_q = 4'd5;
    force dut_r.u_min_o.q_q = 4'd9; force dut_s.u_min_o.q_q = 4'd9;
    force dut_r.u_min_t.q_q = 4'd5; force dut_s.u_min_t.q_q = 4'd5;
    #1;
    release dut_r.u_ms_o.q_q;  release dut_s.u_ms_o.q_q;
    release dut_r.u_ms_t.q_q;  release dut_s.u_ms_t.q_q;
    release dut_r.u_ms_h.q_q;  release dut_s.u_ms_h.q_q;
    release dut_r.u_sec_o.q_q; release dut_s.u_sec_o.q_q;
    release dut_r.u_sec_t.q_q; release dut_s.u_sec_t.q_q;
    release dut_r.u_min_o.q_q; release dut_s.u_min_o.q_q;
    release dut_r.u_min_t.q_q; release dut_s.u_min_t.q_q;

    cyc(0, 0, 0, 0, 0); expect2("preload", 4'd3, mx, mx, 0, 0);
    cyc(0, 0, 0, 0, 1); expect2("wrap", 4'd3, '0, mx, 0, 1);
    cyc(0, 0, 0, 0, 1); expect2("post_wrap", 4'd3, bcd(0, 0, 1), mx, 0, 1);
    ticks(3);           expect2("pre_rst", 4'd3, bcd(0, 0, 4), mx, 0, 1);

    @(posedge clk);
    #3 rst_n = 0;
    #1 expect1("async_rst", 4'd0, '0, 0, 0);
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    cyc(0, 0, 0, 0, 1); expect1("post_rst_tick", 4'd0, '0, 0, 0);
    cyc(1, 0, 0, 0, 0); expect1("post_rst_start", 4'd3, '0, 0, 0);
    ticks(2);           expect1("post_rst_run", 4'd3, bcd(0, 0, 2), 0, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 SHALL have parameter ROLLOVER, default 1: 1 = wrap past 59:59.999 to 00:00.000; 0 = saturate at 59:59.999.
REQ-002 SHALL have port clk, input, 1, system clock, 50 MHz, rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port start_btn, input, 1, debounced single-cycle start request.
REQ-005 SHALL have port stop_btn, input, 1, debounced single-cycle stop request.
REQ-006 SHALL have port reset_btn, input, 1, debounced single-cycle clear request.
REQ-007 SHALL have port lap_btn, input, 1, debounced single-cycle lap toggle.
REQ-008 SHALL have port oneMilliSecond, input, 1, single-cycle tick from the millisecond timer.
REQ-009 SHALL have port state, output, 4, FSM state code; the millisecond timer counts only when state == 4'd3.
REQ-010 SHALL have port digits, output, 28, displayed BCD {min_t, min_o, sec_t, sec_o, ms_h, ms_t, ms_o}, 4 bits each, MSB first.
REQ-011 SHALL have port lap_hold, output, 1, high while the display is frozen.
REQ-012 SHALL have port overflow, output, 1, sticky flag set on the 59:59.999 boundary.

Function
REQ-013 SHALL encode states as IDLE = 4'd0, CLEAR = 4'd1, PAUSED = 4'd2, RUN = 4'd3; other codes are unreachable and SHALL go to CLEAR.
REQ-014 SHALL apply per-cycle button priority reset_btn > stop_btn > start_btn > lap_btn; lower-priority buttons in the same cycle are ignored.
REQ-015 SHALL transition: IDLE + start -> RUN; RUN + stop -> PAUSED; PAUSED + start -> RUN; any state + reset -> CLEAR; CLEAR -> IDLE unconditionally after 1 cycle.
REQ-016 SHALL, in CLEAR, zero the live counter, the lap snapshot, lap_hold and overflow.
REQ-017 SHALL increment the live 7-digit BCD counter by 1 ms on each cycle where oneMilliSecond = 1 and the registered state = RUN, including the cycle in which stop_btn or reset_btn is sampled; the result is visible on the next clock edge.
REQ-018 SHALL ignore oneMilliSecond in IDLE, CLEAR and PAUSED.
REQ-019 SHALL carry ms 999 -> 000 into seconds, seconds 59 -> 00 into minutes; each BCD digit stays 0-9 and tens-of-seconds/minutes stay 0-5.
REQ-020 SHALL, at 59:59.999 + tick, set overflow; with ROLLOVER = 1 it wraps to 00:00.000, with ROLLOVER = 0 it holds 59:59.999; the state remains RUN.
REQ-021 SHALL, on lap_btn in RUN with lap_hold = 0, copy the live counter (pre-increment value of that cycle) into the snapshot and set lap_hold.
REQ-022 SHALL, on lap_btn in RUN or PAUSED with lap_hold = 1, clear lap_hold; lap_btn in IDLE, or in PAUSED with lap_hold = 0, is ignored.
REQ-023 SHALL drive digits = snapshot when lap_hold = 1, else the live counter; counting continues during hold.
REQ-024 SHALL drive all outputs from registers, with no combinational input-to-output path.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force state = IDLE, live counter and snapshot = 0, digits = 28'd0, lap_hold = 0, overflow = 0.
REQ-026 SHALL discard any in-flight tick or button when reset asserts mid-operation; the first post-reset tick is ignored unless the state is RUN.

Structure
REQ-027 SHALL place the state codes and the BCD digit width/limits in the shared stopwatch package, used also by the timer and display driver.
REQ-028 SHALL use one sub-module, bcd_digit, instantiated 7 times: a mod-N BCD digit with increment-in, carry-out and synchronous clear.

Verification
REQ-029 SHALL test: reset, start, 1500 ticks -> digits = 00:01.500, state = 3.
REQ-030 SHALL test: running at 00:00.999, stop_btn and tick in the same cycle -> 00:01.000, state = 2; further ticks -> unchanged.
REQ-031 SHALL test: lap at 00:02.345, 100 more ticks -> digits show 00:02.345 and lap_hold = 1; second lap -> 00:02.445.
REQ-032 SHALL test: preload 59:59.999, tick -> 00:00.000 with overflow = 1 (ROLLOVER = 1), or 59:59.999 with overflow = 1 (ROLLOVER = 0).
REQ-033 SHALL test: start_btn and reset_btn in the same cycle while PAUSED -> state 1 then 0, digits = 0.
REQ-034 SHALL test: rst_n pulsed low mid-RUN between clock edges -> all outputs 0 immediately, state = 0.
